// File: rtl/damage_scheduler.sv
// damage_scheduler: round-robin arbiter for player hit requests with a
// frame-counted invulnerability cooldown and sprite blink phase.
// Ports:
//   pclk       pixel clock, rising edge
//   rst        synchronous active-high reset
//   game_on    high while game screen active
//   game_over  death pulse from HP bar controller
//   vsync_in   vsync; rising edge is a frame tick
//   hit_req    level hit requests, bit i = source i
//   player_hit one-cycle damage pulse to HP bar controller
//   hit_ack    one-hot grant, coincident with player_hit
//   hit_src    index of last granted source (held)
//   invuln     high during cooldown
//   blink      blink phase, meaningful only while invuln=1
//   hit_count  grants in current game, saturating at 255
module damage_scheduler #(
    parameter int unsigned N_SRC         = 4,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned BLINK_FRAMES  = 4
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             game_on,
    input  logic             game_over,
    input  logic             vsync_in,
    input  logic [N_SRC-1:0] hit_req,
    output logic             player_hit,
    output logic [N_SRC-1:0] hit_ack,
    output logic [1:0]       hit_src,
    output logic             invuln,
    output logic             blink,
    output logic [7:0]       hit_count
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_READY,
        ST_COOL
    } state_t;

    state_t             state, state_n;
    logic [1:0]         rr_ptr, rr_ptr_n;
    logic [CNT_W-1:0]   frame_cnt, frame_cnt_n;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_n;
    logic               vsync_d;

    logic               player_hit_n;
    logic [N_SRC-1:0]   hit_ack_n;
    logic [1:0]         hit_src_n;
    logic               invuln_n;
    logic               blink_n;
    logic [7:0]         hit_count_n;

    logic               frame_tick_c;
    logic               grant_vld_c;
    logic [1:0]         grant_idx_c;
    logic [N_SRC-1:0]   req_sh_c;
    int unsigned        cand_c;

    assign frame_tick_c = vsync_in & ~vsync_d;

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = 2'd0;
        cand_c      = 0;
        req_sh_c    = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            cand_c   = (32'(rr_ptr) + i) % N_SRC;
            req_sh_c = hit_req >> cand_c;
            if (!grant_vld_c && req_sh_c[0]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = 2'(cand_c);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n      = state;
        rr_ptr_n     = rr_ptr;
        frame_cnt_n  = frame_cnt;
        blink_cnt_n  = blink_cnt;
        player_hit_n = 1'b0;
        hit_ack_n    = '0;
        hit_src_n    = hit_src;
        invuln_n     = invuln;
        blink_n      = blink;
        hit_count_n  = hit_count;

        case (state)
            ST_OFF: begin
                invuln_n = 1'b0;
                blink_n  = 1'b0;
                if (game_on && !game_over) begin
                    state_n     = ST_READY;
                    hit_count_n = 8'd0;
                    hit_src_n   = 2'd0;
                    rr_ptr_n    = 2'd0;
                end
            end
            ST_READY: begin
                if (!game_on || game_over) begin
                    state_n  = ST_OFF;
                    invuln_n = 1'b0;
                    blink_n  = 1'b0;
                end else if (grant_vld_c) begin
                    state_n      = ST_COOL;
                    player_hit_n = 1'b1;
                    hit_ack_n    = N_SRC'(1) << grant_idx_c;
                    hit_src_n    = grant_idx_c;
                    rr_ptr_n     = 2'((32'(grant_idx_c) + 1) % N_SRC);
                    hit_count_n  = (hit_count == 8'hFF) ? hit_count : hit_count + 8'd1;
                    invuln_n     = 1'b1;
                    blink_n      = 1'b1;
                    frame_cnt_n  = '0;
                    blink_cnt_n  = '0;
                end
            end
            ST_COOL: begin
                if (!game_on || game_over) begin
                    state_n  = ST_OFF;
                    invuln_n = 1'b0;
                    blink_n  = 1'b0;
                end else if (frame_tick_c) begin
                    frame_cnt_n = frame_cnt + CNT_W'(1);
                    if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                        blink_n     = ~blink;
                        blink_cnt_n = '0;
                    end else begin
                        blink_cnt_n = blink_cnt + BLINK_W'(1);
                    end
                    // Last cooldown frame: end takes precedence over a blink toggle.
                    if (frame_cnt == CNT_W'(INVULN_FRAMES - 1)) begin
                        state_n  = ST_READY;
                        invuln_n = 1'b0;
                        blink_n  = 1'b0;
                    end
                end
            end
            default: begin
                state_n  = ST_OFF;
                invuln_n = 1'b0;
                blink_n  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= ST_OFF;
            rr_ptr     <= 2'd0;
            frame_cnt  <= '0;
            blink_cnt  <= '0;
            vsync_d    <= 1'b0;
            player_hit <= 1'b0;
            hit_ack    <= '0;
            hit_src    <= 2'd0;
            invuln     <= 1'b0;
            blink      <= 1'b0;
            hit_count  <= 8'd0;
        end else begin
            state      <= state_n;
            rr_ptr     <= rr_ptr_n;
            frame_cnt  <= frame_cnt_n;
            blink_cnt  <= blink_cnt_n;
            vsync_d    <= vsync_in;
            player_hit <= player_hit_n;
            hit_ack    <= hit_ack_n;
            hit_src    <= hit_src_n;
            invuln     <= invuln_n;
            blink      <= blink_n;
            hit_count  <= hit_count_n;
        end
    end

endmodule

// File: tb/tb_damage_scheduler.sv
// tb_damage_scheduler: directed self-checking bench for damage_scheduler
// with INVULN_FRAMES=3, BLINK_FRAMES=1 and a 20-cycle vsync period.
module tb_damage_scheduler;

    localparam int unsigned N_SRC = 4;

    logic             pclk = 1'b0;
    logic             rst;
    logic             game_on;
    logic             game_over;
    logic             vsync_in;
    logic [N_SRC-1:0] hit_req;
    logic             player_hit;
    logic [N_SRC-1:0] hit_ack;
    logic [1:0]       hit_src;
    logic             invuln;
    logic             blink;
    logic [7:0]       hit_count;

    int n_checks = 0;
    int n_errors = 0;
    int vphase   = 5;
    bit vrise_prev = 1'b0;
    int ticks    = 0;

    always #5 pclk = ~pclk;

    damage_scheduler #(
        .N_SRC        (N_SRC),
        .INVULN_FRAMES(3),
        .BLINK_FRAMES (1)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .game_on   (game_on),
        .game_over (game_over),
        .vsync_in  (vsync_in),
        .hit_req   (hit_req),
        .player_hit(player_hit),
        .hit_ack   (hit_ack),
        .hit_src   (hit_src),
        .invuln    (invuln),
        .blink     (blink),
        .hit_count (hit_count)
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge; tick count covers rising edges already passed.
    task automatic step();
        @(negedge pclk);
        if (vrise_prev) ticks++;
        vphase     = (vphase + 1) % 20;
        vrise_prev = (vphase == 0);
        vsync_in   = (vphase < 2);
    endtask

    // Follow one cooldown from the grant-pulse observation until invuln falls.
    task automatic run_cool(input bit do_pulse);
        int         t0;
        int         d;
        logic [3:0] saved;
        bit         pulsed;
        bit         pulse_on;
        bit         done;
        t0       = ticks;
        saved    = hit_req;
        pulsed   = 1'b0;
        pulse_on = 1'b0;
        done     = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            step();
            d = ticks - t0;
            check_eq("cool_hit", 32'(player_hit), 0);
            check_eq("cool_ack", 32'(hit_ack), 0);
            check_eq("cool_invuln", 32'(invuln), (d < 3) ? 1 : 0);
            check_eq("cool_blink", 32'(blink), ((d < 3) && (d % 2 == 0)) ? 1 : 0);
            if (d >= 3) done = 1'b1;
            if (pulse_on) begin
                hit_req  = saved;
                pulse_on = 1'b0;
            end else if (do_pulse && !pulsed && d == 1) begin
                hit_req  = 4'b0010;
                pulsed   = 1'b1;
                pulse_on = 1'b1;
            end
        end
        if (pulse_on) hit_req = saved;
        check_eq("cool_end", 32'(done), 1);
    endtask

    task automatic wait_grant();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (player_hit) seen = 1'b1;
        end
        check_eq("grant_seen", 32'(seen), 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int prev_t;
        int exp_src;
        rst       = 1'b1;
        game_on   = 1'b0;
        game_over = 1'b0;
        vsync_in  = 1'b0;
        hit_req   = '0;
        repeat (3) step();
        check_eq("rst_hit", 32'(player_hit), 0);
        check_eq("rst_ack", 32'(hit_ack), 0);
        check_eq("rst_src", 32'(hit_src), 0);
        check_eq("rst_invuln", 32'(invuln), 0);
        check_eq("rst_blink", 32'(blink), 0);
        check_eq("rst_count", 32'(hit_count), 0);

        // Single request from source 2, plus ignored mid-cooldown pulse.
        rst     = 1'b0;
        game_on = 1'b1;
        step();
        hit_req = 4'b0100;
        step();
        check_eq("g1_hit", 32'(player_hit), 1);
        check_eq("g1_ack", 32'(hit_ack), 32'b0100);
        check_eq("g1_src", 32'(hit_src), 2);
        check_eq("g1_count", 32'(hit_count), 1);
        check_eq("g1_invuln", 32'(invuln), 1);
        check_eq("g1_blink", 32'(blink), 1);
        hit_req = 4'b0000;
        run_cool(1'b1);

        // Pointer sits at 3: 0110 must grant source 1.
        hit_req = 4'b0110;
        step();
        check_eq("g2_hit", 32'(player_hit), 1);
        check_eq("g2_src", 32'(hit_src), 1);
        check_eq("g2_ack", 32'(hit_ack), 32'b0010);
        check_eq("g2_count", 32'(hit_count), 2);
        hit_req = 4'b0000;
        run_cool(1'b0);

        // Leave and re-enter the game.
        game_on = 1'b0;
        step();
        check_eq("off_invuln", 32'(invuln), 0);
        check_eq("off_count_hold", 32'(hit_count), 2);
        check_eq("off_src_hold", 32'(hit_src), 1);
        game_on = 1'b1;
        step();
        check_eq("on_count_clr", 32'(hit_count), 0);
        check_eq("on_src_clr", 32'(hit_src), 0);

        // Level-held requests: rotation 0,1,2,3,... and saturation.
        hit_req = 4'b1111;
        prev_t  = 0;
        for (int n = 1; n <= 301; n++) begin
            wait_grant();
            exp_src = (n - 1) % 4;
            check_eq("held_src", 32'(hit_src), 32'(exp_src));
            check_eq("held_ack", 32'(hit_ack), 32'(1) << exp_src);
            check_eq("held_count", 32'(hit_count), (n > 255) ? 255 : 32'(n));
            if (n > 1) check_eq("held_ticks", 32'(ticks - prev_t), 3);
            prev_t = ticks;
            if (n < 301) run_cool(1'b0);
        end

        // Abort mid-cooldown with game_over, then restart.
        repeat (3) step();
        check_eq("abort_pre_invuln", 32'(invuln), 1);
        game_over = 1'b1;
        step();
        check_eq("abort_invuln", 32'(invuln), 0);
        check_eq("abort_blink", 32'(blink), 0);
        check_eq("abort_hit", 32'(player_hit), 0);
        check_eq("abort_count", 32'(hit_count), 255);
        game_over = 1'b0;
        game_on   = 1'b0;
        hit_req   = 4'b0000;
        step();
        check_eq("abort_off_count", 32'(hit_count), 255);
        game_on = 1'b1;
        step();
        check_eq("restart_count", 32'(hit_count), 0);
        check_eq("restart_src", 32'(hit_src), 0);
        hit_req = 4'b1001;
        step();
        check_eq("restart_ptr_src", 32'(hit_src), 0);
        check_eq("restart_ack", 32'(hit_ack), 32'b0001);
        check_eq("restart_grant_count", 32'(hit_count), 1);
        hit_req = 4'b0000;
        run_cool(1'b0);

        // game_over beats a simultaneous request.
        hit_req   = 4'b0100;
        game_over = 1'b1;
        step();
        check_eq("prio_hit", 32'(player_hit), 0);
        check_eq("prio_ack", 32'(hit_ack), 0);
        check_eq("prio_count", 32'(hit_count), 1);
        game_over = 1'b0;
        hit_req   = 4'b0000;
        step();
        check_eq("prio_reenter_count", 32'(hit_count), 0);

        // Reset in the middle of a cooldown.
        hit_req = 4'b0100;
        step();
        check_eq("pre_rst_hit", 32'(player_hit), 1);
        check_eq("pre_rst_src", 32'(hit_src), 2);
        hit_req = 4'b0000;
        repeat (3) step();
        check_eq("pre_rst_invuln", 32'(invuln), 1);
        rst = 1'b1;
        step();
        check_eq("mid_rst_hit", 32'(player_hit), 0);
        check_eq("mid_rst_ack", 32'(hit_ack), 0);
        check_eq("mid_rst_src", 32'(hit_src), 0);
        check_eq("mid_rst_invuln", 32'(invuln), 0);
        check_eq("mid_rst_blink", 32'(blink), 0);
        check_eq("mid_rst_count", 32'(hit_count), 0);
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
